controle_entrada_bcd: RTL and testbench

Digit-entry controller for a bank of N_DIG `bcd_registrador`-style 4-bit digit registers. It accepts key codes through a valid/ready handshake and keeps a shadow copy of the entered number. For every edit (new digit, backspace, clear) it sequences the whole bank through one shared `d` bus and one-hot `ld` strobes, one register per cycle. It sits between the keypad decoder and the display/operand register bank, and reports fill level, a confirmation state and error pulses.

---
 rtl/controle_entrada_bcd.sv | 204 ++++++++++++++++++++
 tb/tb_controle_entrada_bcd.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/controle_entrada_bcd.sv
// controle_entrada_bcd
//   Digit-entry controller for a bank of N_DIG 4-bit digit registers.
//   Accepts key codes over a valid/ready handshake and keeps a shadow copy
//   of the entered number. After every edit (digit, backspace, clear) it
//   rewrites the whole bank through the shared d bus and the one-hot ld
//   strobes, one register per cycle, from the top index down to index 0.
//
// Ports
//   ck           in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   tecla_valida in   key strobe (valid)
//   tecla        in   key code: 0-9 digit, A backspace, B clear, C confirm
//   tecla_pronta out  ready; key accepted when valid && ready at an edge
//   ld           out  one-hot load strobes to the digit registers
//   d            out  shared data bus to the digit registers
//   n_dig        out  number of digits entered, 0..N_DIG
//   cheio        out  high while n_dig == N_DIG
//   confirmado   out  high while the entry is locked
//   erro         out  one-cycle pulse when a key is rejected
module controle_entrada_bcd #(
    parameter int N_DIG = 4
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             tecla_valida,
    input  logic [3:0]       tecla,
    output logic             tecla_pronta,
    output logic [N_DIG-1:0] ld,
    output logic [3:0]       d,
    output logic [3:0]       n_dig,
    output logic             cheio,
    output logic             confirmado,
    output logic             erro
);

    localparam int              IW      = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [IW-1:0]   IDX_TOP = IW'(N_DIG - 1);
    localparam logic [3:0]      N_MAX   = 4'(N_DIG);

    localparam logic [3:0] K_APAGAR    = 4'hA;
    localparam logic [3:0] K_LIMPAR    = 4'hB;
    localparam logic [3:0] K_CONFIRMAR = 4'hC;

    typedef enum logic [1:0] {
        INICIO,
        ESCREVE,
        OCIOSO,
        CONFIRMADO
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [N_DIG-1:0][3:0]   shadow_q, shadow_d;
    logic [3:0]              n_dig_q, n_dig_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [N_DIG-1:0]        ld_q, ld_d;
    logic [3:0]              bus_q, bus_d;
    logic                    pronta_q, pronta_d;
    logic                    cheio_q, cheio_d;
    logic                    conf_q, conf_d;
    logic                    erro_q, erro_d;
    logic                    inicia;

    always_comb begin
        estado_d = estado_q;
        shadow_d = shadow_q;
        n_dig_d  = n_dig_q;
        idx_d    = idx_q;
        ld_d     = '0;
        bus_d    = '0;
        pronta_d = 1'b0;
        conf_d   = conf_q;
        erro_d   = 1'b0;
        inicia   = 1'b0;

        case (estado_q)
            INICIO: begin
                shadow_d = '0;
                n_dig_d  = '0;
                inicia   = 1'b1;
            end

            ESCREVE: begin
                // idx_q is the register being strobed this cycle; the next
                // register's strobe and data are prepared for the next edge.
                if (idx_q == '0) begin
                    estado_d = OCIOSO;
                    pronta_d = 1'b1;
                end else begin
                    idx_d            = idx_q - 1'b1;
                    ld_d[idx_d]      = 1'b1;
                    bus_d            = shadow_q[idx_d];
                end
            end

            OCIOSO: begin
                pronta_d = 1'b1;
                if (tecla_valida) begin
                    if (tecla < K_APAGAR) begin
                        if (n_dig_q < N_MAX) begin
                            for (int unsigned i = N_DIG - 1; i > 0; i--) begin
                                shadow_d[i] = shadow_q[i-1];
                            end
                            shadow_d[0] = tecla;
                            n_dig_d     = n_dig_q + 4'd1;
                            inicia      = 1'b1;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end else if (tecla == K_APAGAR) begin
                        if (n_dig_q != 4'd0) begin
                            for (int unsigned i = 0; i < N_DIG - 1; i++) begin
                                shadow_d[i] = shadow_q[i+1];
                            end
                            shadow_d[N_DIG-1] = '0;
                            n_dig_d           = n_dig_q - 4'd1;
                            inicia            = 1'b1;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end else if (tecla == K_LIMPAR) begin
                        shadow_d = '0;
                        n_dig_d  = '0;
                        inicia   = 1'b1;
                    end else if (tecla == K_CONFIRMAR) begin
                        if (n_dig_q != 4'd0) begin
                            estado_d = CONFIRMADO;
                            conf_d   = 1'b1;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end

            CONFIRMADO: begin
                pronta_d = 1'b1;
                if (tecla_valida) begin
                    if (tecla == K_LIMPAR) begin
                        conf_d   = 1'b0;
                        shadow_d = '0;
                        n_dig_d  = '0;
                        inicia   = 1'b1;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end

            default: begin
                estado_d = INICIO;
            end
        endcase

        // Every edit starts a full rewrite from the top register, driving the
        // already-updated shadow so the first strobe lands on this edge.
        if (inicia) begin
            estado_d       = ESCREVE;
            idx_d          = IDX_TOP;
            ld_d           = '0;
            ld_d[IDX_TOP]  = 1'b1;
            bus_d          = shadow_d[IDX_TOP];
            pronta_d       = 1'b0;
        end

        cheio_d = (n_dig_d == N_MAX);
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= INICIO;
            shadow_q <= '0;
            n_dig_q  <= '0;
            idx_q    <= '0;
            ld_q     <= '0;
            bus_q    <= '0;
            pronta_q <= 1'b0;
            cheio_q  <= 1'b0;
            conf_q   <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            shadow_q <= shadow_d;
            n_dig_q  <= n_dig_d;
            idx_q    <= idx_d;
            ld_q     <= ld_d;
            bus_q    <= bus_d;
            pronta_q <= pronta_d;
            cheio_q  <= cheio_d;
            conf_q   <= conf_d;
            erro_q   <= erro_d;
        end
    end

    assign tecla_pronta = pronta_q;
    assign ld           = ld_q;
    assign d            = bus_q;
    assign n_dig        = n_dig_q;
    assign cheio        = cheio_q;
    assign confirmado   = conf_q;
    assign erro         = erro_q;

endmodule

// File: tb/tb_controle_entrada_bcd.sv
// tb_controle_entrada_bcd
//   Self-checking bench for controle_entrada_bcd with N_DIG = 4. A model of
//   the digit-register bank captures d on the falling edge wherever ld is
//   set, so the bank contents can be compared against hand-computed values.
module tb_controle_entrada_bcd;

    logic       ck = 1'b0;
    logic       rst_n = 1'b0;
    logic       tecla_valida = 1'b0;
    logic [3:0] tecla = 4'h0;
    logic       tecla_pronta;
    logic [3:0] ld;
    logic [3:0] d;
    logic [3:0] n_dig;
    logic       cheio;
    logic       confirmado;
    logic       erro;

    int checks = 0;
    int errors = 0;

    controle_entrada_bcd #(.N_DIG(4)) dut (
        .ck           (ck),
        .rst_n        (rst_n),
        .tecla_valida (tecla_valida),
        .tecla        (tecla),
        .tecla_pronta (tecla_pronta),
        .ld           (ld),
        .d            (d),
        .n_dig        (n_dig),
        .cheio        (cheio),
        .confirmado   (confirmado),
        .erro         (erro)
    );

    always #5 ck = ~ck;

    // Digit-register bank model: captures at the falling edge.
    logic [3:0] bank [4];
    int         wr_tot = 0;
    always @(negedge ck) begin
        for (int i = 0; i < 4; i++) begin
            if (ld[i]) bank[i] = d;
        end
        if (ld != 4'b0) wr_tot++;
    end

    function automatic logic [15:0] bank_word();
        return {bank[3], bank[2], bank[1], bank[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next falling edge and check bus invariants.
    task automatic tick();
        @(negedge ck);
        #1;
        chk("ld_onehot", 32'($countones(ld) <= 1), 32'd1);
        chk("d_idle_zero", 32'((ld == 4'b0) && (d != 4'h0)), 32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!tecla_pronta && n < 30) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(tecla_pronta), 32'd1);
    endtask

    typedef struct {
        logic [3:0]  key;
        logic        e_erro;
        int          e_wr;
        logic [3:0]  e_nd;
        logic        e_cheio;
        logic        e_conf;
        logic [15:0] e_bank;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] key, input logic e_erro, input int e_wr,
                                input logic [3:0] e_nd, input logic e_cheio,
                                input logic e_conf, input logic [15:0] e_bank);
        vec_t v;
        v.key = key; v.e_erro = e_erro; v.e_wr = e_wr; v.e_nd = e_nd;
        v.e_cheio = e_cheio; v.e_conf = e_conf; v.e_bank = e_bank;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int k);
        int start;
        wait_ready();
        start        = wr_tot;
        tecla_valida = 1'b1;
        tecla        = v.key;
        tick();
        tecla_valida = 1'b0;
        chk($sformatf("v%0d_erro", k), 32'(erro), 32'(v.e_erro));
        chk($sformatf("v%0d_conf", k), 32'(confirmado), 32'(v.e_conf));
        tick();
        chk($sformatf("v%0d_erro_pulse", k), 32'(erro), 32'd0);
        wait_ready();
        chk($sformatf("v%0d_writes", k), 32'(wr_tot - start), 32'(v.e_wr));
        chk($sformatf("v%0d_n_dig", k), 32'(n_dig), 32'(v.e_nd));
        chk($sformatf("v%0d_cheio", k), 32'(cheio), 32'(v.e_cheio));
        chk($sformatf("v%0d_conf_end", k), 32'(confirmado), 32'(v.e_conf));
        chk($sformatf("v%0d_bank", k), 32'(bank_word()), 32'(v.e_bank));
    endtask

    task automatic check_clear_seq(input string tag);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("%s_ld%0d", tag, i), 32'(ld), 32'd1 << (3 - i));
            chk($sformatf("%s_d%0d", tag, i), 32'(d), 32'd0);
            chk($sformatf("%s_pronta%0d", tag, i), 32'(tecla_pronta), 32'd0);
            chk($sformatf("%s_erro%0d", tag, i), 32'(erro), 32'd0);
            if (i == 3) tecla_valida = 1'b0;
        end
        tick();
        chk($sformatf("%s_pronta", tag), 32'(tecla_pronta), 32'd1);
        chk($sformatf("%s_ld_end", tag), 32'(ld), 32'd0);
        chk($sformatf("%s_n_dig", tag), 32'(n_dig), 32'd0);
        chk($sformatf("%s_bank", tag), 32'(bank_word()), 32'h0000);
    endtask

    vec_t vecs [25];

    initial begin
        vecs[0]  = mk(4'h1, 0, 4, 4'd1, 0, 0, 16'h0001);
        vecs[1]  = mk(4'h2, 0, 4, 4'd2, 0, 0, 16'h0012);
        vecs[2]  = mk(4'h3, 0, 4, 4'd3, 0, 0, 16'h0123);
        vecs[3]  = mk(4'hA, 0, 4, 4'd2, 0, 0, 16'h0012);
        vecs[4]  = mk(4'hA, 0, 4, 4'd1, 0, 0, 16'h0001);
        vecs[5]  = mk(4'hA, 0, 4, 4'd0, 0, 0, 16'h0000);
        vecs[6]  = mk(4'hA, 1, 0, 4'd0, 0, 0, 16'h0000);
        vecs[7]  = mk(4'hB, 0, 4, 4'd0, 0, 0, 16'h0000);
        vecs[8]  = mk(4'h9, 0, 4, 4'd1, 0, 0, 16'h0009);
        vecs[9]  = mk(4'h8, 0, 4, 4'd2, 0, 0, 16'h0098);
        vecs[10] = mk(4'h7, 0, 4, 4'd3, 0, 0, 16'h0987);
        vecs[11] = mk(4'h6, 0, 4, 4'd4, 1, 0, 16'h9876);
        vecs[12] = mk(4'h5, 1, 0, 4'd4, 1, 0, 16'h9876);
        vecs[13] = mk(4'hC, 0, 0, 4'd4, 1, 1, 16'h9876);
        vecs[14] = mk(4'h7, 1, 0, 4'd4, 1, 1, 16'h9876);
        vecs[15] = mk(4'hE, 1, 0, 4'd4, 1, 1, 16'h9876);
        vecs[16] = mk(4'hB, 0, 4, 4'd0, 0, 0, 16'h0000);
        vecs[17] = mk(4'hC, 1, 0, 4'd0, 0, 0, 16'h0000);
        vecs[18] = mk(4'hD, 1, 0, 4'd0, 0, 0, 16'h0000);
        vecs[19] = mk(4'h4, 0, 4, 4'd1, 0, 0, 16'h0004);
        vecs[20] = mk(4'h2, 0, 4, 4'd2, 0, 0, 16'h0042);
        vecs[21] = mk(4'hC, 0, 0, 4'd2, 0, 1, 16'h0042);
        vecs[22] = mk(4'hA, 1, 0, 4'd2, 0, 1, 16'h0042);
        vecs[23] = mk(4'hB, 0, 4, 4'd0, 0, 0, 16'h0000);
        vecs[24] = mk(4'h7, 0, 4, 4'd1, 0, 0, 16'h0007);

        // Reset state.
        tick();
        tick();
        chk("rst_ld", 32'(ld), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_pronta", 32'(tecla_pronta), 32'd0);
        chk("rst_n_dig", 32'(n_dig), 32'd0);
        chk("rst_cheio", 32'(cheio), 32'd0);
        chk("rst_conf", 32'(confirmado), 32'd0);
        chk("rst_erro", 32'(erro), 32'd0);

        // Release with an invalid key held: must be ignored while writing.
        tecla_valida = 1'b1;
        tecla        = 4'hF;
        rst_n        = 1'b1;
        check_clear_seq("init");

        for (int k = 0; k < 25; k++) apply(vecs[k], k);

        // Reset asserted during the second write cycle of key 5 (from 7).
        wait_ready();
        tecla_valida = 1'b1;
        tecla        = 4'h5;
        tick();
        tecla_valida = 1'b0;
        chk("mid_ld0", 32'(ld), 32'h8);
        chk("mid_n_dig0", 32'(n_dig), 32'd2);
        tick();
        chk("mid_ld1", 32'(ld), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ld", 32'(ld), 32'd0);
        chk("mid_rst_d", 32'(d), 32'd0);
        chk("mid_rst_n_dig", 32'(n_dig), 32'd0);
        chk("mid_rst_pronta", 32'(tecla_pronta), 32'd0);
        chk("mid_bank_pre", 32'(bank_word()), 32'h0007);
        tick();
        rst_n = 1'b1;
        check_clear_seq("rerst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
